// File: rtl/proc_run_ctrl.sv
// Processor run controller: produces the clk_div8 enable for the clock/reset
// manager and sequences start delay, run, halt and single-step in the clk_in domain.
module proc_run_ctrl #(
  parameter int START_DELAY = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst_async_n,
  input  logic             rst_sync_n,
  input  logic             clk_div8,
  input  logic             start,
  input  logic             halt,
  input  logic             step,
  output logic             en_clk_div8,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] proc_cycles,
  output logic [2:0]       dbg_state
);

  // The delay counter holds 0..START_DELAY-1; the last value plus one rise means "go".
  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = (START_DELAY > 0) ? DLY_W'(START_DELAY - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DELAY  = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_div8_q;
  logic             w_rise;
  logic             r_halt_pend;
  logic             w_halt_pend_nxt;
  logic [DLY_W-1:0] r_dly_cnt;
  logic [DLY_W-1:0] w_dly_nxt;
  logic             w_clr_cnt;
  logic             w_en_nxt;
  logic             r_en;
  logic             r_running;
  logic             r_halted;
  logic [CNT_W-1:0] r_cycles;

  // clk_div8 is treated as data; a rise is seen on the clk_in edge after it goes high.
  assign w_rise = clk_div8 & ~r_div8_q;

  always_ff @(posedge clk_in or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_state     <= S_IDLE;
      r_div8_q    <= 1'b0;
      r_halt_pend <= 1'b0;
      r_dly_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_div8_q    <= clk_div8;
      r_halt_pend <= w_halt_pend_nxt;
      r_dly_cnt   <= w_dly_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_halt_pend_nxt = 1'b0;
    w_dly_nxt       = r_dly_cnt;
    w_clr_cnt       = 1'b0;
    if (!rst_sync_n) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A coincident halt suppresses the start.
          if (start && !halt) begin
            w_clr_cnt   = 1'b1;
            w_dly_nxt   = '0;
            w_state_nxt = (START_DELAY == 0) ? S_RUN : S_DELAY;
          end
        end
        S_DELAY: begin
          if (halt) begin
            w_state_nxt = S_HALTED;
          end else if (w_rise) begin
            if (r_dly_cnt == DLY_LAST) begin
              w_state_nxt = S_RUN;
            end else begin
              w_dly_nxt = r_dly_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          // Halt only lands on a clk_div8 rise so the last enabled edge is whole.
          if (w_rise && (halt || r_halt_pend)) begin
            w_state_nxt = S_HALTED;
          end else begin
            w_halt_pend_nxt = r_halt_pend | halt;
          end
        end
        S_STEP: begin
          if (w_rise) begin
            w_state_nxt = S_HALTED;
          end
        end
        S_HALTED: begin
          if (halt) begin
            w_state_nxt = S_HALTED;
          end else if (start) begin
            w_state_nxt = S_RUN;
          end else if (step) begin
            w_state_nxt = S_STEP;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign w_en_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);

  // Outputs are registered decodes of the next state, so they track r_state exactly.
  always_ff @(posedge clk_in or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_en      <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_en      <= w_en_nxt;
      r_running <= w_en_nxt;
      r_halted  <= (w_state_nxt == S_HALTED);
    end
  end

  // Counts rises on which the manager would have latched an enable of 1.
  always_ff @(posedge clk_in or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_cycles <= '0;
    end else if (w_clr_cnt) begin
      r_cycles <= '0;
    end else if (w_rise && r_en) begin
      r_cycles <= r_cycles + CNT_W'(1);
    end
  end

  assign en_clk_div8 = r_en;
  assign running     = r_running;
  assign halted      = r_halted;
  assign proc_cycles = r_cycles;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: a vector table for the main sequence of the
// default instance, plus hand-written async-reset, wrap and zero-delay sequences.
module tb_proc_run_ctrl;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DELAY  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_STEP   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  // ---------------- clock / reset block ----------------
  logic       clk_in = 1'b0;
  logic [2:0] div_cnt = 3'd0;
  logic       clk_div8;
  logic       div_at_edge = 1'b0;

  always #5 clk_in = ~clk_in;

  // Divider advances 1 time unit after each clk_in edge; div_at_edge is what the DUT sampled.
  always @(posedge clk_in) begin
    #1;
    div_cnt = div_cnt + 3'd1;
  end
  assign clk_div8 = div_cnt[2];

  always @(posedge clk_in) div_at_edge <= clk_div8;

  // ---------------- DUT A: defaults ----------------
  logic        rst_async_n = 1'b0;
  logic        rst_sync_n  = 1'b0;
  logic        start = 1'b0, halt = 1'b0, step = 1'b0;
  logic        en_a, run_a, hlt_a;
  logic [31:0] pc_a;
  logic [2:0]  st_a;

  proc_run_ctrl u_dut (
    .clk_in      (clk_in),
    .rst_async_n (rst_async_n),
    .rst_sync_n  (rst_sync_n),
    .clk_div8    (clk_div8),
    .start       (start),
    .halt        (halt),
    .step        (step),
    .en_clk_div8 (en_a),
    .running     (run_a),
    .halted      (hlt_a),
    .proc_cycles (pc_a),
    .dbg_state   (st_a)
  );

  // ---------------- DUT B: CNT_W=4, START_DELAY=0 ----------------
  logic       rst_async_n_b = 1'b0;
  logic       rst_sync_n_b  = 1'b0;
  logic       start_b = 1'b0, halt_b = 1'b0, step_b = 1'b0;
  logic       en_b, run_b, hlt_b;
  logic [3:0] pc_b;
  logic [2:0] st_b;

  proc_run_ctrl #(.START_DELAY(0), .CNT_W(4)) u_dut_b (
    .clk_in      (clk_in),
    .rst_async_n (rst_async_n_b),
    .rst_sync_n  (rst_sync_n_b),
    .clk_div8    (clk_div8),
    .start       (start_b),
    .halt        (halt_b),
    .step        (step_b),
    .en_clk_div8 (en_b),
    .running     (run_b),
    .halted      (hlt_b),
    .proc_cycles (pc_b),
    .dbg_state   (st_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns at posedge+3 of the clk_in edge on which the DUT sees a clk_div8 rise.
  task automatic wait_rise_eff();
    logic last;
    bit   found;
    last  = div_at_edge;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk_in);
      #3;
      if (div_at_edge && !last) found = 1'b1;
      last = div_at_edge;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rise_timeout: got none expected a clk_div8 rise within 20 cycles");
    end
  endtask

  typedef struct {
    logic        rs;
    logic        s;
    logic        h;
    logic        st;
    int          nr;
    logic        en;
    logic        run;
    logic        hlt;
    logic [31:0] pc;
    logic [2:0]  state;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic s, input logic h, input logic st,
                              input int nr, input logic en, input logic run, input logic hlt,
                              input logic [31:0] pc, input logic [2:0] state);
    vec_t v;
    v.rs = rs; v.s = s; v.h = h; v.st = st; v.nr = nr;
    v.en = en; v.run = run; v.hlt = hlt; v.pc = pc; v.state = state;
    return v;
  endfunction

  vec_t vecs[23];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rs s  h  st nr  en run hlt pc  state
    vecs[0]  = mk(1, 1, 0, 0, 0,  0, 0,  0,  0,  ST_DELAY);
    vecs[1]  = mk(1, 0, 0, 0, 1,  0, 0,  0,  0,  ST_DELAY);
    vecs[2]  = mk(1, 0, 0, 0, 1,  0, 0,  0,  0,  ST_DELAY);
    vecs[3]  = mk(1, 0, 0, 0, 1,  0, 0,  0,  0,  ST_DELAY);
    vecs[4]  = mk(1, 0, 0, 0, 1,  1, 1,  0,  0,  ST_RUN);
    vecs[5]  = mk(1, 0, 0, 0, 10, 1, 1,  0,  10, ST_RUN);
    vecs[6]  = mk(1, 0, 1, 0, 0,  1, 1,  0,  10, ST_RUN);
    vecs[7]  = mk(1, 0, 0, 0, 1,  0, 0,  1,  11, ST_HALTED);
    vecs[8]  = mk(1, 0, 0, 1, 0,  1, 1,  0,  11, ST_STEP);
    vecs[9]  = mk(1, 0, 0, 0, 1,  0, 0,  1,  12, ST_HALTED);
    vecs[10] = mk(1, 0, 0, 1, 0,  1, 1,  0,  12, ST_STEP);
    vecs[11] = mk(1, 0, 0, 0, 1,  0, 0,  1,  13, ST_HALTED);
    vecs[12] = mk(1, 0, 0, 1, 0,  1, 1,  0,  13, ST_STEP);
    vecs[13] = mk(1, 0, 1, 0, 0,  1, 1,  0,  13, ST_STEP);
    vecs[14] = mk(1, 0, 0, 0, 1,  0, 0,  1,  14, ST_HALTED);
    vecs[15] = mk(1, 1, 1, 0, 0,  0, 0,  1,  14, ST_HALTED);
    vecs[16] = mk(1, 1, 0, 1, 0,  1, 1,  0,  14, ST_RUN);
    vecs[17] = mk(1, 0, 0, 1, 0,  1, 1,  0,  14, ST_RUN);
    vecs[18] = mk(1, 1, 0, 0, 1,  1, 1,  0,  15, ST_RUN);
    vecs[19] = mk(0, 0, 0, 0, 0,  0, 0,  0,  15, ST_IDLE);
    vecs[20] = mk(0, 0, 0, 0, 1,  0, 0,  0,  15, ST_IDLE);
    vecs[21] = mk(1, 1, 0, 0, 0,  0, 0,  0,  0,  ST_DELAY);
    vecs[22] = mk(1, 0, 1, 0, 0,  0, 0,  1,  0,  ST_HALTED);

    // Reset state
    repeat (3) @(posedge clk_in);
    #3;
    chk("rst_en",    {31'd0, en_a},  32'd0);
    chk("rst_run",   {31'd0, run_a}, 32'd0);
    chk("rst_halt",  {31'd0, hlt_a}, 32'd0);
    chk("rst_pc",    pc_a,           32'd0);
    chk("rst_state", {29'd0, st_a},  {29'd0, ST_IDLE});
    chk("rst_pc_b",  {28'd0, pc_b},  32'd0);

    rst_async_n   = 1'b1;
    rst_async_n_b = 1'b1;
    @(posedge clk_in); #3;
    rst_sync_n   = 1'b1;
    rst_sync_n_b = 1'b1;
    @(posedge clk_in); #3;
    chk("idle_en", {31'd0, en_a}, 32'd0);
    chk("idle_state", {29'd0, st_a}, {29'd0, ST_IDLE});

    // Main table, aligned just after a clk_div8 rise
    wait_rise_eff();
    for (int i = 0; i < 23; i++) begin
      rst_sync_n = vecs[i].rs;
      start      = vecs[i].s;
      halt       = vecs[i].h;
      step       = vecs[i].st;
      @(posedge clk_in); #3;
      start = 1'b0;
      halt  = 1'b0;
      step  = 1'b0;
      for (int r = 0; r < vecs[i].nr; r++) wait_rise_eff();
      chk($sformatf("v%0d_en", i),    {31'd0, en_a},  {31'd0, vecs[i].en});
      chk($sformatf("v%0d_run", i),   {31'd0, run_a}, {31'd0, vecs[i].run});
      chk($sformatf("v%0d_halt", i),  {31'd0, hlt_a}, {31'd0, vecs[i].hlt});
      chk($sformatf("v%0d_pc", i),    pc_a,           vecs[i].pc);
      chk($sformatf("v%0d_state", i), {29'd0, st_a},  {29'd0, vecs[i].state});
    end

    // Async reset between clk_in edges clears outputs immediately (from HALTED)
    #2;
    rst_async_n = 1'b0;
    #1;
    chk("async_halt_halted", {31'd0, hlt_a}, 32'd0);
    chk("async_halt_state",  {29'd0, st_a},  {29'd0, ST_IDLE});
    @(posedge clk_in); #3;
    rst_async_n = 1'b1;
    @(posedge clk_in); #3;

    // Async reset mid-DELAY
    start = 1'b1;
    @(posedge clk_in); #3;
    start = 1'b0;
    wait_rise_eff();
    chk("dly_state", {29'd0, st_a}, {29'd0, ST_DELAY});
    #2;
    rst_async_n = 1'b0;
    #1;
    chk("async_dly_state", {29'd0, st_a},  {29'd0, ST_IDLE});
    chk("async_dly_en",    {31'd0, en_a},  32'd0);
    chk("async_dly_run",   {31'd0, run_a}, 32'd0);
    chk("async_dly_halt",  {31'd0, hlt_a}, 32'd0);
    chk("async_dly_pc",    pc_a,           32'd0);

    // Instance B: no start delay, 4-bit counter wrap
    wait_rise_eff();
    start_b = 1'b1;
    @(posedge clk_in); #3;
    start_b = 1'b0;
    chk("b_start_en",  {31'd0, en_b},  32'd1);
    chk("b_start_run", {31'd0, run_b}, 32'd1);
    chk("b_start_pc",  {28'd0, pc_b},  32'd0);
    for (int r = 0; r < 17; r++) wait_rise_eff();
    chk("b_wrap_pc", {28'd0, pc_b}, 32'd1);

    // Halt landing on the same edge as a clk_div8 rise
    for (int i = 0; i < 16 && !(clk_div8 && !div_at_edge); i++) begin
      @(posedge clk_in); #3;
    end
    halt_b = 1'b1;
    @(posedge clk_in); #3;
    halt_b = 1'b0;
    chk("b_halt_rise_halted", {31'd0, hlt_b}, 32'd1);
    chk("b_halt_rise_en",     {31'd0, en_b},  32'd0);
    chk("b_halt_rise_pc",     {28'd0, pc_b},  32'd2);

    // Resume: a stale halt_pend would halt on the next rise
    start_b = 1'b1;
    @(posedge clk_in); #3;
    start_b = 1'b0;
    wait_rise_eff();
    chk("b_resume_run",   {31'd0, run_b}, 32'd1);
    chk("b_resume_state", {29'd0, st_b},  {29'd0, ST_RUN});
    chk("b_resume_pc",    {28'd0, pc_b},  32'd3);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
